// File: rtl/alu_pipe.sv
// Pipelined ARM-style ALU with a barrel shifter on operand 2, condition codes, and an
// iterative shift-add multiplier. There is a one-deep result register with valid/ready handshaking.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SH_W  = 5,
    parameter int PC_W  = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       Cond,
    input  logic [3:0]       OP,
    input  logic             S,
    input  logic [2:0]       SRcon,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [SH_W-1:0]  i_shiftamt,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_executed,
    output logic [3:0]       o_Conflags,
    output logic [PC_W-1:0]  o_programcounter,
    output logic             o_busy
);
    localparam logic [3:0] OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
                           OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_ORR = 4'd7,
                           OP_MOV = 4'd8,  OP_MVN = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
                           OP_TST = 4'd12, OP_MUL = 4'd13;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;
    state_t state, state_next;

    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = o_Conflags;

    logic accept;
    assign accept = i_valid && o_ready;

    // Operand-2 shifter; the extra bit of each wide shift captures the last bit shifted out
    logic [WIDTH:0]   lsl_w, lsr_w, asr_w;
    logic [WIDTH-1:0] ror_v, op2;
    logic [SH_W-1:0]  neg_amt;
    logic             shift_c;

    assign neg_amt = -i_shiftamt;
    assign lsl_w   = {1'b0, i_in2} << i_shiftamt;
    assign lsr_w   = {i_in2, 1'b0} >> i_shiftamt;
    assign asr_w   = $signed({i_in2, 1'b0}) >>> i_shiftamt;
    assign ror_v   = (i_in2 >> i_shiftamt) | (i_in2 << neg_amt);

    always_comb begin
        op2     = i_in2;
        shift_c = flag_c;
        if (i_shiftamt != '0) begin
            case (SRcon)
                3'd1:    {shift_c, op2} = lsl_w;
                3'd2:    {op2, shift_c} = lsr_w;
                3'd3:    {op2, shift_c} = asr_w;
                3'd4:    begin op2 = ror_v; shift_c = ror_v[WIDTH-1]; end
                default: ;
            endcase
        end
    end

    // Shared adder: subtracts are a + ~b + cin so the carry out is ARM's NOT-borrow
    logic [WIDTH-1:0] add_a, add_b;
    logic             add_cin, add_v;
    logic [WIDTH:0]   add_sum;

    always_comb begin
        add_a   = i_in1;
        add_b   = op2;
        add_cin = 1'b0;
        case (OP)
            OP_SUB, OP_CMP: begin add_b = ~op2; add_cin = 1'b1; end
            OP_RSB:         begin add_a = op2; add_b = ~i_in1; add_cin = 1'b1; end
            OP_ADC:         add_cin = flag_c;
            OP_SBC:         begin add_b = ~op2; add_cin = flag_c; end
            default: ;
        endcase
    end

    assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign add_v   = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);

    logic [WIDTH-1:0] alu_res;
    logic             is_arith, writes_res, is_compare;

    always_comb begin
        alu_res    = op2;
        is_arith   = 1'b0;
        writes_res = 1'b1;
        is_compare = 1'b0;
        case (OP)
            OP_AND: alu_res = i_in1 & op2;
            OP_EOR: alu_res = i_in1 ^ op2;
            OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC: begin
                alu_res  = add_sum[WIDTH-1:0];
                is_arith = 1'b1;
            end
            OP_ORR: alu_res = i_in1 | op2;
            OP_MVN: alu_res = ~op2;
            OP_CMP, OP_CMN: begin
                alu_res    = add_sum[WIDTH-1:0];
                is_arith   = 1'b1;
                writes_res = 1'b0;
                is_compare = 1'b1;
            end
            OP_TST: begin
                alu_res    = i_in1 & op2;
                writes_res = 1'b0;
                is_compare = 1'b1;
            end
            default: alu_res = op2;
        endcase
    end

    logic [3:0] new_flags;
    assign new_flags = {alu_res[WIDTH-1], alu_res == '0,
                        is_arith ? add_sum[WIDTH] : shift_c,
                        is_arith ? add_v : flag_v};

    logic cond_pass;
    always_comb begin
        case (Cond)
            4'd0:    cond_pass = flag_z;
            4'd1:    cond_pass = !flag_z;
            4'd2:    cond_pass = flag_c;
            4'd3:    cond_pass = !flag_c;
            4'd4:    cond_pass = flag_n;
            4'd5:    cond_pass = !flag_n;
            4'd6:    cond_pass = flag_v;
            4'd7:    cond_pass = !flag_v;
            4'd8:    cond_pass = flag_c && !flag_z;
            4'd9:    cond_pass = !flag_c || flag_z;
            4'd10:   cond_pass = flag_n == flag_v;
            4'd11:   cond_pass = flag_n != flag_v;
            4'd12:   cond_pass = !flag_z && (flag_n == flag_v);
            4'd13:   cond_pass = flag_z || (flag_n != flag_v);
            4'd14:   cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    logic [WIDTH-1:0] mul_acc, mul_cand, mul_plier, mul_acc_next;
    logic [SH_W-1:0]  mul_cnt;
    logic             mul_s, mul_last;

    assign mul_acc_next = mul_plier[0] ? mul_acc + mul_cand : mul_acc;
    assign mul_last     = (mul_cnt == SH_W'(WIDTH - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && cond_pass && OP == OP_MUL) state_next = ST_MUL;
            ST_MUL:  if (mul_last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == ST_IDLE) && (!o_valid || i_ready);
        o_busy  = (state == ST_MUL);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            o_result         <= '0;
            o_Conflags       <= '0;
            o_programcounter <= '0;
            o_valid          <= 1'b0;
            o_executed       <= 1'b0;
            mul_acc          <= '0;
            mul_cand         <= '0;
            mul_plier        <= '0;
            mul_cnt          <= '0;
            mul_s            <= 1'b0;
        end else if (accept) begin
            o_programcounter <= o_programcounter + PC_W'(1);
            if (!cond_pass) begin
                o_valid    <= 1'b1;
                o_executed <= 1'b0;
            end else if (OP == OP_MUL) begin
                o_valid   <= 1'b0;
                mul_acc   <= '0;
                mul_cand  <= i_in1;
                mul_plier <= op2;
                mul_cnt   <= '0;
                mul_s     <= S;
            end else begin
                o_valid    <= 1'b1;
                o_executed <= 1'b1;
                if (writes_res) o_result <= alu_res;
                if (S || is_compare) o_Conflags <= new_flags;
            end
        end else if (state == ST_MUL) begin
            mul_acc   <= mul_acc_next;
            mul_cand  <= mul_cand << 1;
            mul_plier <= mul_plier >> 1;
            mul_cnt   <= mul_cnt + SH_W'(1);
            if (mul_last) begin
                o_result   <= mul_acc_next;
                o_valid    <= 1'b1;
                o_executed <= 1'b1;
                if (mul_s) o_Conflags[3:2] <= {mul_acc_next[WIDTH-1], mul_acc_next == '0};
            end
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (>=8, power of 2).
REQ-002 SHALL have parameter SH_W, default 5, shift-amount width, equal to log2(WIDTH).
REQ-003 SHALL have parameter PC_W, default 8, program counter width.
REQ-004 SHALL have ports:
- Clk  in  1  clock; all state changes on rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  instruction offered.
- o_ready  out  1  instruction accepted when i_valid && o_ready.
- Cond  in  4  ARM condition code.
- OP  in  4  opcode.
- S  in  1  set flags.
- SRcon  in  3  operand-2 shift mode.
- i_in1  in  WIDTH  first operand (Rn).
- i_in2  in  WIDTH  second operand, before the shifter.
- i_shiftamt  in  SH_W  shift amount.
- o_valid  out  1  result available.
- i_ready  in  1  consumer takes the result when o_valid && i_ready.
- o_result  out  WIDTH  registered result.
- o_executed  out  1  condition passed for the presented result.
- o_Conflags  out  4  NZCV flag register.
- o_programcounter  out  PC_W  count of accepted instructions.
- o_busy  out  1  multiply in progress.

Function
REQ-005 SHALL use opcodes 0 AND, 1 EOR, 2 SUB (in1-op2), 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 ORR, 8 MOV, 9 MVN, 10 CMP, 11 CMN, 12 TST, 13 MUL (in1*op2, low WIDTH bits); opcodes 14-15 SHALL act as MOV.
REQ-006 SHALL shift operand 2 by SRcon: 0 none, 1 LSL, 2 LSR, 3 ASR, 4 ROR; SRcon 5-7 SHALL mean none; amount 0 SHALL mean no shift.
REQ-007 SHALL evaluate Cond (0 EQ ... 14 AL, 15 never) against o_Conflags at the acceptance cycle.
REQ-008 SHALL drive o_ready = (state==IDLE) && (!o_valid || i_ready).
REQ-009 SHALL have FSM states IDLE and MUL; an accepted MUL with its condition passing SHALL go IDLE->MUL; every other accepted instruction SHALL stay in IDLE.
REQ-010 For a non-MUL instruction accepted in cycle N, o_valid SHALL be 1 in cycle N+1.
REQ-011 MUL SHALL use shift-add, one bit per cycle, for WIDTH cycles; o_valid SHALL assert in the cycle after the last step, then the FSM returns to IDLE; o_busy=1 while in MUL.
REQ-012 A failed condition SHALL set o_valid with o_executed=0, keep o_result and o_Conflags unchanged, and take 1 cycle even for MUL.
REQ-013 A passing instruction SHALL load o_result, except CMP, CMN and TST, which SHALL leave o_result unchanged; o_executed SHALL be 1.
REQ-014 Flags SHALL update only when the condition passes and either S=1 or the opcode is CMP, CMN or TST:
- N = result[WIDTH-1].
- Z = (result==0).
- Add-type ops: C = carry out.
- Subtract-type ops: C = NOT borrow (ARM convention).
- Logical ops: C = last bit shifted out; C unchanged when there is no shift.
- V = signed overflow for arithmetic ops only; unchanged otherwise.
- MUL: only N and Z are written.
REQ-015 Flags written by instruction k SHALL be visible to the condition of instruction k+1 with no stall.
REQ-016 o_programcounter SHALL increment by 1 on every acceptance, including failed conditions, and wrap modulo 2^PC_W.
REQ-017 While o_valid && !i_ready, o_result, o_executed and o_valid SHALL hold.
REQ-018 o_valid SHALL clear when the result is taken with no new result in the same cycle.
REQ-019 A take and an acceptance in the same cycle SHALL be legal and give full throughput.

Reset
REQ-020 Rst_n=0 SHALL asynchronously force:
- state = IDLE.
- o_result, o_Conflags, o_programcounter, o_valid, o_executed and o_busy = 0.
- The multiplier accumulator, counter and operands = 0.
REQ-021 Reset during MUL SHALL abort the multiply with no result; o_ready SHALL be 1 in the first cycle after Rst_n rises.

Verification (WIDTH=32)
REQ-022 ADD, S=1, i_in1=7, i_in2=4, Cond=AL -> next cycle o_result=11, NZCV=0000, o_executed=1, o_programcounter=1.
REQ-023 SUB, S=1, i_in1=5, i_in2=10 -> o_result=0xFFFFFFFB, NZCV=1000; then CMP 10,5 -> NZCV=0010, o_result stays 0xFFFFFFFB.
REQ-024 ADD, S=1, 0x7FFFFFFF+1 -> NZCV=1001; next MOV with Cond=LT -> o_executed=0, o_result unchanged, o_programcounter still increments.
REQ-025 MOV, SRcon=2, i_shiftamt=4, i_in2=0x0F000F00 -> o_result=0x00F000F0; same with SRcon=4, i_shiftamt=8 -> 0x000F000F.
REQ-026 MUL 3*7 -> o_busy=1 and o_ready=0 for 32 cycles, o_result=21 on o_valid; repeat, and assert Rst_n=0 at step 10 -> all outputs 0, no o_valid.
REQ-027 Hold i_ready=0 for 3 cycles after a result -> o_result and o_valid stable, o_ready=0; release -> next instruction accepted in the same cycle.
